arith_pipe: RTL and testbench

Parametrised, back-pressurable two-operand arithmetic pipeline. It adds wrap-around and saturating add/subtract modes, per-result carry/borrow reporting, a sticky overflow flag and a delivered-result counter. It sits between an operand producer and a result consumer, both using valid/ready handshakes. It generalises the fixed single-mode adder stage.

---
 rtl/arith_pipe_pkg.sv | 25 ++
 rtl/arith_pipe_alu.sv | 73 +++++++
 rtl/arith_pipe.sv | 159 +++++++++++++++
 tb/tb_arith_pipe.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pipe_pkg.sv
// ---------------------------------------------------------------------------
// arith_pipe_pkg
//
// Shared definitions for the arith_pipe family:
//   - op_e      : 2-bit operation encoding carried with every operand beat
//   - LAT_MIN / LAT_MAX : legal range of the pipeline depth parameter
//
// No ports (package).
// ---------------------------------------------------------------------------
package arith_pipe_pkg;

    // Operation selector. The encoding is part of the external interface
    // (the producer drives these raw values on `op`), so it must not change.
    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,  // wrap-around add,      ovf = carry
        OP_SUB  = 2'd1,  // wrap-around subtract, ovf = borrow
        OP_ADDS = 2'd2,  // saturating add (clamps to all-ones)
        OP_SUBS = 2'd3   // saturating subtract (clamps to zero)
    } op_e;

    // Legal pipeline depth, in register stages.
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

endpackage : arith_pipe_pkg

// File: rtl/arith_pipe_alu.sv
// ---------------------------------------------------------------------------
// arith_pipe_alu
//
// Purely combinational two-operand unsigned add/subtract unit with
// wrap-around and saturating modes. Shared by the single-channel pipeline
// and its multi-channel variants.
//
// Parameters
//   W      : operand / result width (>= 2)
//
// Ports
//   op_i   in  2 : operation (see arith_pipe_pkg::op_e)
//   a_i    in  W : unsigned operand A
//   b_i    in  W : unsigned operand B
//   y_o    out W : result
//   ovf_o  out 1 : carry (add modes) or borrow (subtract modes)
// ---------------------------------------------------------------------------
module arith_pipe_alu
    import arith_pipe_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [1:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o,
    output logic         ovf_o
);

    // Both results are formed one bit wider than the operands. For the sum
    // the extra MSB is the carry; for the difference the extra MSB is set
    // exactly when a < b, i.e. it is the borrow.
    logic [W:0] sum;
    logic [W:0] diff;
    logic       carry;
    logic       borrow;
    op_e        op_sel;

    always_comb begin
        sum    = {1'b0, a_i} + {1'b0, b_i};
        diff   = {1'b0, a_i} - {1'b0, b_i};
        carry  = sum[W];
        borrow = diff[W];
        op_sel = op_e'(op_i);

        y_o   = sum[W-1:0];
        ovf_o = carry;

        case (op_sel)
            OP_ADD: begin
                y_o   = sum[W-1:0];
                ovf_o = carry;
            end
            OP_SUB: begin
                y_o   = diff[W-1:0];
                ovf_o = borrow;
            end
            OP_ADDS: begin
                y_o   = carry ? {W{1'b1}} : sum[W-1:0];
                ovf_o = carry;
            end
            OP_SUBS: begin
                y_o   = borrow ? {W{1'b0}} : diff[W-1:0];
                ovf_o = borrow;
            end
            default: begin
                y_o   = sum[W-1:0];
                ovf_o = carry;
            end
        endcase
    end

endmodule : arith_pipe_alu

// File: rtl/arith_pipe.sv
// ---------------------------------------------------------------------------
// arith_pipe
//
// Back-pressurable, LAT-stage arithmetic pipeline between an operand
// producer and a result consumer. Each accepted beat carries its own
// operation, so modes can be interleaved freely. Also keeps a sticky
// overflow flag (set at acceptance) and a wrapping delivered-result counter.
//
// Parameters
//   W      : operand / result width (>= 2)
//   LAT    : pipeline depth in register stages (LAT_MIN..LAT_MAX)
//   CNT_W  : width of the delivered-result counter
//
// Ports
//   clk         in  1     : clock
//   rst_n       in  1     : asynchronous active-low reset
//   in_valid    in  1     : operand beat valid
//   in_ready    out 1     : block accepts the beat this cycle
//   op          in  2     : operation, sampled with the beat
//   a, b        in  W     : unsigned operands
//   out_valid   out 1     : result presented
//   out_ready   in  1     : consumer takes the result
//   y           out W     : result
//   y_ovf       out 1     : carry/borrow of the presented result
//   ovf_sticky  out 1     : set by any accepted beat with carry/borrow
//   clr_ovf     in  1     : synchronous clear of ovf_sticky (set wins)
//   res_cnt     out CNT_W : number of delivered results (wraps)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The producer may raise or drop in_valid at will; in_ready does not
// depend on in_valid. A presented result (out_valid = 1) is held stable,
// together with y and y_ovf, until the consumer takes it with out_ready.
// ---------------------------------------------------------------------------
module arith_pipe
    import arith_pipe_pkg::*;
#(
    parameter int W     = 16,
    parameter int LAT   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     y,
    output logic             y_ovf,
    output logic             ovf_sticky,
    input  logic             clr_ovf,
    output logic [CNT_W-1:0] res_cnt
);

    // -----------------------------------------------------------------------
    // Combinational ALU feeding stage 0
    // -----------------------------------------------------------------------
    logic [W-1:0] alu_y;
    logic         alu_ovf;

    arith_pipe_alu #(
        .W (W)
    ) u_alu (
        .op_i  (op),
        .a_i   (a),
        .b_i   (b),
        .y_o   (alu_y),
        .ovf_o (alu_ovf)
    );

    // -----------------------------------------------------------------------
    // Stage registers. Index 0 is the entry stage, LAT-1 drives the outputs.
    // -----------------------------------------------------------------------
    logic [LAT-1:0]        vld_q;
    logic [LAT-1:0][W-1:0] y_q;
    logic [LAT-1:0]        ovf_q;

    logic adv;     // whole pipeline moves one position this cycle
    logic accept;  // an operand beat is taken this cycle
    logic deliver; // the consumer takes the presented result this cycle

    // A single global advance: the pipe only stalls when the last stage
    // holds a result the consumer refuses. Bubbles in earlier stages are not
    // squeezed out, which keeps the stall path a single AND/OR and still
    // gives full throughput whenever out_ready is held high.
    assign adv     = !vld_q[LAT-1] || out_ready;
    assign accept  = in_valid && adv;
    assign deliver = vld_q[LAT-1] && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            y_q   <= '0;
            ovf_q <= '0;
        end else if (adv) begin
            // Stage 0 valid follows in_valid directly: no beat means a bubble.
            vld_q[0] <= in_valid;
            y_q[0]   <= alu_y;
            ovf_q[0] <= alu_ovf;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                y_q[i]   <= y_q[i-1];
                ovf_q[i] <= ovf_q[i-1];
            end
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[LAT-1];
    assign y         = y_q[LAT-1];
    assign y_ovf     = ovf_q[LAT-1];

    // -----------------------------------------------------------------------
    // Sticky overflow flag. Set is taken from the ALU at acceptance so that
    // software sees the overflow even while the result is stuck in the pipe.
    // A set in the same cycle as a clear must win, hence the ordering below.
    // -----------------------------------------------------------------------
    logic sticky_q;
    logic sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (clr_ovf) begin
            sticky_d = 1'b0;
        end
        if (accept && alu_ovf) begin
            sticky_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Delivered-result counter, free-running with natural wrap.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (deliver) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ovf_sticky = sticky_q;
    assign res_cnt    = cnt_q;

endmodule : arith_pipe

// File: tb/tb_arith_pipe.sv
module tb_arith_pipe;

  localparam int W     = 16;
  localparam int LAT   = 2;
  localparam int CNT_W = 8;

  typedef struct {
    logic [W-1:0] y;
    logic         ovf;
    int           acc;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic             clk       = 1'b0;
  logic             rst_n     = 1'b1;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b1;
  logic             clr_ovf   = 1'b0;
  logic [1:0]       op        = 2'd0;
  logic [W-1:0]     a         = '0;
  logic [W-1:0]     b         = '0;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     y;
  logic             y_ovf;
  logic             ovf_sticky;
  logic [CNT_W-1:0] res_cnt;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  arith_pipe #(.W(W), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .y          (y),
    .y_ovf      (y_ovf),
    .ovf_sticky (ovf_sticky),
    .clr_ovf    (clr_ovf),
    .res_cnt    (res_cnt)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [W-1:0] got_q[$];
  int last_stall = -1;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation rules.
  function automatic void ref_calc(input logic [1:0] o, input int unsigned x, input int unsigned z,
                                   output logic [W-1:0] r, output logic f);
    int unsigned modv;
    int unsigned s;
    modv = 1 << W;
    s    = x + z;
    case (o)
      2'd0: begin r = W'(s % modv); f = (s >= modv); end
      2'd1: begin r = (x >= z) ? W'(x - z) : W'(x + modv - z); f = (x < z); end
      2'd2: begin r = (s >= modv) ? W'(modv - 1) : W'(s); f = (s >= modv); end
      default: begin r = (x < z) ? W'(0) : W'(x - z); f = (x < z); end
    endcase
  endfunction

  function automatic int unsigned pop_got();
    if (got_q.size() == 0) return 32'hFFFF_FFFF;
    return int'(got_q.pop_front());
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z, input logic clr);
    int t;
    logic [W-1:0] r;
    logic f;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = z;
    clr_ovf  = clr;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (in_ready) begin
      ref_calc(o, x, z, r, f);
      exp_q.push_back('{y: r, ovf: f, acc: cyc});
    end else begin
      check("send_timeout", 0, 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clr_ovf  = 1'b0;
    end
  endtask

  task automatic clr_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    clr_ovf  = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      idle(1);
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    clr_ovf   = 1'b0;
    out_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
  endtask

  // ---------------- monitor / model ----------------
  logic             exp_sticky = 1'b0;
  logic [CNT_W-1:0] exp_cnt    = '0;
  logic             prev_stall = 1'b0;
  logic [W-1:0]     prev_y     = '0;

  always begin
    logic         nxt;
    logic [W-1:0] r;
    logic         f;
    exp_t         e;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_y", y, 0);
      check("rst_y_ovf", y_ovf, 0);
      check("rst_sticky", ovf_sticky, 0);
      check("rst_res_cnt", res_cnt, 0);
      exp_sticky = 1'b0;
      exp_cnt    = '0;
      prev_stall = 1'b0;
    end else begin
      check("sticky", ovf_sticky, exp_sticky);
      check("res_cnt", res_cnt, exp_cnt);
      check("in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_y", y, prev_y);
      end
      if (out_valid && !out_ready) begin
        prev_stall = 1'b1;
        prev_y     = y;
        last_stall = cyc;
      end else begin
        prev_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got y=0x%0h, required no result", y);
        end else begin
          e = exp_q.pop_front();
          check("y", y, e.y);
          check("y_ovf", y_ovf, e.ovf);
          if (e.acc > last_stall) check("latency", cyc - e.acc, LAT);
          got_q.push_back(y);
        end
        exp_cnt = exp_cnt + 1'b1;
      end
      nxt = exp_sticky;
      if (clr_ovf) nxt = 1'b0;
      if (in_valid && in_ready) begin
        ref_calc(op, a, b, r, f);
        if (f) nxt = 1'b1;
      end
      exp_sticky = nxt;
    end
  end

  // ---------------- stimulus ----------------
  logic rnd_done;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset then ADD
    send(2'd0, 16'h1234, 16'h0001, 1'b0);
    drain();
    check("add_y", pop_got(), 16'h1235);
    check("add_res_cnt", res_cnt, 1);
    check("add_sticky", ovf_sticky, 0);

    // Mode sweep
    got_q.delete();
    send(2'd0, 16'hFFFF, 16'h0002, 1'b0);
    send(2'd2, 16'hFFFF, 16'h0002, 1'b0);
    send(2'd1, 16'h0001, 16'h0003, 1'b0);
    send(2'd3, 16'h0001, 16'h0003, 1'b0);
    drain();
    check("sweep_add", pop_got(), 16'h0001);
    check("sweep_adds", pop_got(), 16'hFFFF);
    check("sweep_sub", pop_got(), 16'hFFFE);
    check("sweep_subs", pop_got(), 16'h0000);
    check("sweep_sticky", ovf_sticky, 1);

    // Sticky priority
    clr_cycle();
    idle(1);
    check("clr_sticky", ovf_sticky, 0);
    send(2'd2, 16'hFFFF, 16'hFFFF, 1'b1);
    idle(1);
    check("set_wins", ovf_sticky, 1);
    clr_cycle();
    idle(1);
    check("clr_alone", ovf_sticky, 0);
    drain();

    // Backpressure
    reset_dut();
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'd0, W'(i), W'(i), 1'b0);
        idle(1);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 6; i++) check("bp_seq", pop_got(), 2 * i);
    check("bp_res_cnt", res_cnt, 6);

    // Randomized modes, random backpressure, counter wrap
    reset_dut();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 256; i++) begin
          send(2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
               ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
               1'($urandom_range(0, 7) == 0));
        end
        idle(1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("wrap_res_cnt", res_cnt, 0);

    // Reset mid-flight
    send(2'd0, 16'h0010, 16'h0020, 1'b0);
    send(2'd1, 16'h0030, 16'h0040, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check("midrst_res_cnt", res_cnt, 0);
    check("midrst_out_valid_after", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
